pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer: the next generation of the combinational PC+1 incrementer.
- Holds the architectural PC in a register and selects the next PC each cycle from: increment, relative branch, absolute jump, call/return (via a return-address stack), or trap vector.
- Supports a pipeline stall.
- Sits between the control unit and instruction memory in the single-cycle core; `pc` drives the instruction-memory address.

Parameters:
- ADDR_W, 32, PC width in bits; all PC arithmetic is modulo 2^ADDR_W.
- STEP, 1, increment per sequential instruction (word-addressed memory).
- RESET_VEC, 0, PC value loaded on reset.
- TRAP_VEC, 16, PC value loaded on trap or return-stack underflow.
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and stack this cycle (ignored by trap).
- branch_take  in  1  take relative branch.
- branch_off  in  ADDR_W  signed offset, relative to current pc.
- jump  in  1  absolute jump to jump_target.
- call  in  1  jump to jump_target and push pc+STEP.
- jump_target  in  ADDR_W  absolute target for jump/call.
- ret  in  1  pop the stack into pc.
- trap  in  1  force pc to TRAP_VEC.
- pc  out  ADDR_W  current PC (registered).
- pc_plus1  out  ADDR_W  combinational pc+STEP.
- ras_empty  out  1  stack holds 0 entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.
- ras_overflow  out  1  one-cycle registered pulse: push while full.
- err_underflow  out  1  sticky: ret while empty; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): pc=RESET_VEC, stack count=0, ras_empty=1, ras_full=0, ras_overflow=0, err_underflow=0.
- Reset mid-operation discards all stack contents and pending flags immediately.
- Next-PC priority, evaluated every rising edge:
  1. trap → pc=TRAP_VEC; stack unchanged; stall ignored.
  2. stall → pc and stack hold; ras_overflow=0.
  3. ret:
     - stack non-empty → pc=top; count−1.
     - stack empty → pc=TRAP_VEC; err_underflow=1; count stays 0.
  4. call → pc=jump_target; push pc+STEP.
  5. jump → pc=jump_target.
  6. branch_take → pc=pc+branch_off (two's-complement, wraps modulo 2^ADDR_W).
  7. otherwise → pc=pc+STEP (0xFFFF_FFFF → 0x0000_0000 for ADDR_W=32).
- Simultaneous requests: the highest-priority request wins and all lower ones are ignored, with no side effects. For example, ret+call pops only; jump+branch jumps.
- Stack push when full:
  - Circular buffer; the push overwrites the oldest entry.
  - count stays RAS_DEPTH.
  - ras_overflow=1 for the following cycle.
  - The subsequent RAS_DEPTH returns yield the newest RAS_DEPTH addresses in LIFO order.
- ras_overflow is cleared on any cycle without an overflowing push.
- Latency:
  - Control inputs take effect on pc at the next edge (1 cycle).
  - pc_plus1 tracks pc combinationally (0 cycles).
- Stack status: count range 0..RAS_DEPTH. ras_empty and ras_full are derived from the registered count.

Decomposition:
- Shared package pc_seq_pkg:
  - next-PC select enum (SEL_INC, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET, SEL_TRAP).
  - Default vector constants.
- Sub-module ras_stack: parametrised by ADDR_W and RAS_DEPTH.
  - Ports: push, pop, push_data, top, empty, full, overflow.
  - Internals: circular pointer plus count.
- Top-level: priority encoder plus PC register.

Test Plan:
- Reset and increment: rst_n low with pc random, release; run 3 cycles → pc sequence 0,1,2,3; pc_plus1 = pc+1 each cycle.
- Branch, jump, wrap:
  - pc=0x10, branch_off=−4 → pc=0x0C.
  - jump_target=0x200 → pc=0x200.
  - pc=0xFFFF_FFFF with no control → pc=0x0000_0000.
- Call/return nesting:
  - From pc 0x20, call 0x100; from 0x100, call 0x300 → count=2.
  - ret → pc=0x101; ret → pc=0x21; ras_empty=1.
- Stack overflow (RAS_DEPTH=4):
  - 5 calls from pcs 0x0, 0x10, 0x20, 0x30, 0x40 → ras_overflow pulses once after the 5th call; ras_full=1.
  - 4 rets → pc=0x41, 0x31, 0x21, 0x11.
  - 5th ret → pc=TRAP_VEC, err_underflow=1.
- Priority and stall:
  - stall with branch_take → pc unchanged.
  - stall with trap → pc=TRAP_VEC.
  - ret and call together with a 1-entry stack → pop only; count=0.
- Async reset mid-stack: 2 entries pushed, rst_n asserted mid-cycle → pc=RESET_VEC immediately; ras_empty=1; err_underflow=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC select codes
// and the default vector/size constants used as parameter defaults.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      SEL_INC,
      SEL_BR,
      SEL_JMP,
      SEL_CALL,
      SEL_RET,
      SEL_TRAP
   } sel_t;

   localparam int DEF_ADDR_W    = 32;
   localparam int DEF_STEP      = 1;
   localparam int DEF_RESET_VEC = 0;
   localparam int DEF_TRAP_VEC  = 16;
   localparam int DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address stack: circular buffer with saturating count; a push while
// full overwrites the oldest entry and raises a one-cycle overflow pulse.
module ras_stack #(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full,
   output logic              overflow
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  top_ptr;
   logic [CNT_W-1:0]  count;

   // Entry contents need no reset: count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push && full;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!full)
               count <= count + 1'b1;
         end else if (pop && !empty) begin
            wr_ptr <= wr_ptr - 1'b1;
            count  <= count - 1'b1;
         end
      end
   end

   assign top_ptr = wr_ptr - 1'b1;
   assign top     = mem[top_ptr];
   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(RAS_DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: priority-selects the next PC (trap, stall, ret,
// call, jump, branch, increment) and keeps a return-address stack for calls.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] STEP      = ADDR_W'(DEF_STEP),
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
   parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(DEF_TRAP_VEC),
   parameter int                RAS_DEPTH = DEF_RAS_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              branch_take,
   input  logic [ADDR_W-1:0] branch_off,
   input  logic              jump,
   input  logic              call,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              ret,
   input  logic              trap,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus1,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_overflow,
   output logic              err_underflow
);

   sel_t              sel;
   logic              advance;
   logic              push;
   logic              pop;
   logic              underflow;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] ras_top;

   assign pc_plus1 = pc + STEP;

   always_comb begin
      sel = SEL_INC;
      if (trap)             sel = SEL_TRAP;
      else if (ret)         sel = SEL_RET;
      else if (call)        sel = SEL_CALL;
      else if (jump)        sel = SEL_JMP;
      else if (branch_take) sel = SEL_BR;
   end

   // Trap overrides stall; every other request waits while stalled.
   assign advance   = trap || !stall;
   assign push      = advance && (sel == SEL_CALL);
   assign pop       = advance && (sel == SEL_RET) && !ras_empty;
   assign underflow = advance && (sel == SEL_RET) && ras_empty;

   always_comb begin
      pc_next = pc_plus1;
      case (sel)
         SEL_TRAP: pc_next = TRAP_VEC;
         SEL_RET:  pc_next = ras_empty ? TRAP_VEC : ras_top;
         SEL_CALL: pc_next = jump_target;
         SEL_JMP:  pc_next = jump_target;
         SEL_BR:   pc_next = pc + branch_off;
         default:  pc_next = pc_plus1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc            <= RESET_VEC;
         err_underflow <= 1'b0;
      end else begin
         if (advance)
            pc <= pc_next;
         if (underflow)
            err_underflow <= 1'b1;
      end
   end

   ras_stack #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (pc_plus1),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .overflow  (ras_overflow)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test of pc_sequencer with default parameters (32-bit PC, STEP 1,
// RESET_VEC 0, TRAP_VEC 0x10, 4-entry return stack).
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        branch_take;
   logic [31:0] branch_off;
   logic        jump;
   logic        call;
   logic [31:0] jump_target;
   logic        ret;
   logic        trap;
   logic [31:0] pc;
   logic [31:0] pc_plus1;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_overflow;
   logic        err_underflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch_take   (branch_take),
      .branch_off    (branch_off),
      .jump          (jump),
      .call          (call),
      .jump_target   (jump_target),
      .ret           (ret),
      .trap          (trap),
      .pc            (pc),
      .pc_plus1      (pc_plus1),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .ras_overflow  (ras_overflow),
      .err_underflow (err_underflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   task automatic idle();
      stall = 0; branch_take = 0; branch_off = '0; jump = 0; call = 0;
      jump_target = '0; ret = 0; trap = 0;
   endtask

   // One clock edge with the currently driven controls, then release them.
   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_jump(input logic [31:0] t);
      jump = 1; jump_target = t; step();
   endtask

   task automatic do_call(input logic [31:0] t);
      call = 1; jump_target = t; step();
   endtask

   task automatic do_ret();
      ret = 1; step();
   endtask

   initial begin
      idle();
      rst_n = 0;
      jump = 1; jump_target = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      #1;
      check("reset_pc", pc, 32'h0);
      check("reset_empty", {31'b0, ras_empty}, 32'd1);
      check("reset_full", {31'b0, ras_full}, 32'd0);
      check("reset_ovf", {31'b0, ras_overflow}, 32'd0);
      check("reset_err", {31'b0, err_underflow}, 32'd0);
      idle();
      rst_n = 1;
      check("rel_pc_plus1", pc_plus1, 32'h1);

      // Sequential increment
      for (int i = 1; i <= 3; i++) begin
         step();
         check("inc_pc", pc, 32'(i));
         check("inc_pc_plus1", pc_plus1, 32'(i + 1));
      end

      // Branch, jump priority over branch, wrap-around
      do_jump(32'h10);
      branch_take = 1; branch_off = -32'sd4; step();
      check("branch_back", pc, 32'h0C);
      jump = 1; jump_target = 32'h200; branch_take = 1; branch_off = 32'h40; step();
      check("jump_over_branch", pc, 32'h200);
      do_jump(32'hFFFF_FFFF);
      check("pc_plus1_wrap", pc_plus1, 32'h0);
      step();
      check("inc_wrap", pc, 32'h0);

      // Nested call / return
      do_jump(32'h20);
      do_call(32'h100);
      check("call1_pc", pc, 32'h100);
      do_call(32'h300);
      check("call2_pc", pc, 32'h300);
      check("call2_empty", {31'b0, ras_empty}, 32'd0);
      do_ret();
      check("ret1_pc", pc, 32'h101);
      do_ret();
      check("ret2_pc", pc, 32'h21);
      check("ret2_empty", {31'b0, ras_empty}, 32'd1);

      // Overflow: five calls into a four-entry stack
      do_jump(32'h0);
      for (int i = 1; i <= 5; i++) begin
         do_call(32'(i * 16));
         check("ovf_call_pc", pc, 32'(i * 16));
         check("ovf_pulse", {31'b0, ras_overflow}, (i == 5) ? 32'd1 : 32'd0);
         if (i >= 4) check("ovf_full", {31'b0, ras_full}, 32'd1);
      end
      do_ret();
      check("ovf_ret1", pc, 32'h41);
      check("ovf_pulse_clr", {31'b0, ras_overflow}, 32'd0);
      do_ret();
      check("ovf_ret2", pc, 32'h31);
      do_ret();
      check("ovf_ret3", pc, 32'h21);
      do_ret();
      check("ovf_ret4", pc, 32'h11);
      check("ovf_empty", {31'b0, ras_empty}, 32'd1);
      check("pre_uf_err", {31'b0, err_underflow}, 32'd0);
      do_ret();
      check("uf_pc", pc, 32'h10);
      check("uf_err", {31'b0, err_underflow}, 32'd1);
      check("uf_empty", {31'b0, ras_empty}, 32'd1);
      step();
      check("uf_err_sticky", {31'b0, err_underflow}, 32'd1);

      // Stall and priority
      do_jump(32'h80);
      stall = 1; branch_take = 1; branch_off = 32'h8; step();
      check("stall_branch", pc, 32'h80);
      stall = 1; trap = 1; step();
      check("stall_trap", pc, 32'h10);
      do_call(32'h40);
      check("one_entry_empty", {31'b0, ras_empty}, 32'd0);
      stall = 1; ret = 1; step();
      check("stall_ret_pc", pc, 32'h40);
      check("stall_ret_keep", {31'b0, ras_empty}, 32'd0);
      ret = 1; call = 1; jump_target = 32'h500; step();
      check("ret_call_pc", pc, 32'h11);
      check("ret_call_empty", {31'b0, ras_empty}, 32'd1);
      trap = 1; ret = 1; step();
      check("trap_over_ret", pc, 32'h10);

      // Asynchronous reset mid-stack (err_underflow is set at this point)
      do_jump(32'h20);
      do_call(32'h100);
      do_call(32'h300);
      check("pre_rst_empty", {31'b0, ras_empty}, 32'd0);
      #2 rst_n = 0;
      #1;
      check("arst_pc", pc, 32'h0);
      check("arst_empty", {31'b0, ras_empty}, 32'd1);
      check("arst_err", {31'b0, err_underflow}, 32'd0);
      @(negedge clk);
      rst_n = 1;
      step();
      check("post_rst_inc", pc, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
